itlb_assoc: RTL and testbench
=============================

Name: itlb_assoc

Overview:
- Parametrised, fully associative instruction TLB; next generation of the 4-entry iTLB.
- Sits between the fetch stage and the instruction memory and translates virtual fetch addresses to physical addresses.
- Adds: configurable depth and widths, true-LRU replacement, duplicate-free refill, and per-page user permission with fault reporting.
- Adds a registered lookup response with a valid strobe; supervisor accesses bypass translation.

Parameters:
- ENTRIES, 4, number of TLB entries; power of two, 2..32.
- VA_WIDTH, 32, virtual address width.
- PAGE_BITS, 12, page offset width.
- PPN_WIDTH, 8, physical page number width. PA width PA_W = PPN_WIDTH+PAGE_BITS; VPN width VPN_W = VA_WIDTH-PAGE_BITS.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- flush  in  1  invalidate all entries.
- req_valid  in  1  lookup request this cycle.
- VirtualAddress  in  VA_WIDTH  fetch address; sampled when req_valid=1.
- supervisor_mode  in  1  1 = translation bypass for this request.
- tlb_write  in  1  refill strobe.
- reg_logic_page  in  VPN_W  VPN to install.
- reg_physical_page  in  PPN_WIDTH  PPN to install.
- reg_user_ok  in  1  1 = page accessible in user mode.
- resp_valid  out  1  one-cycle pulse; response fields valid.
- PhysicalAddress  out  PA_W  translated address.
- tlb_miss  out  1  no valid matching entry.
- tlb_fault  out  1  hit on a page with user_ok=0 in user mode.

Behaviour:
- State per entry: valid, vpn[VPN_W], ppn[PPN_WIDTH], user_ok, age[log2(ENTRIES)].
- Reset (reset=0 at edge): all valid=0; age[i]=i. resp_valid, PhysicalAddress, tlb_miss and tlb_fault are all 0. Reset overrides every other input, including a request in flight; no response is produced for it.
- Lookup latency is 1 cycle. A request at edge N gives resp_valid=1 during cycle N+1.
  - resp_valid=0 the cycle after a cycle with req_valid=0.
  - Response fields hold their last value while resp_valid=0.
- Supervisor request: PhysicalAddress = VirtualAddress[PA_W-1:0], tlb_miss=0, tlb_fault=0. No age update.
- User request, hit (valid and vpn == VirtualAddress[VA_WIDTH-1:PAGE_BITS]):
  - PhysicalAddress = {ppn, VirtualAddress[PAGE_BITS-1:0]}, tlb_miss=0.
  - If user_ok=1: tlb_fault=0 and the LRU is updated.
  - If user_ok=0: tlb_fault=1, PhysicalAddress=0, no LRU update.
- User request, miss: tlb_miss=1, tlb_fault=0, PhysicalAddress=0, no state change.
- At most one entry may match. Refill guarantees this; the matcher uses a priority encoder with the lowest index winning.
- LRU update (touch of entry h): every entry with age < age[h] increments; age[h] becomes 0. Ages therefore always form a permutation of 0..ENTRIES-1.
- Refill when tlb_write=1:
  - Target selection priority: valid entry with vpn == reg_logic_page (overwrite in place), else lowest-index invalid entry, else the entry with age == ENTRIES-1.
  - Write vpn, ppn, user_ok; set valid=1; touch the target.
  - Refill takes effect at the edge and is visible to requests on the next edge.
- Flush: all valid=0 at the edge; ages unchanged.
- Same-cycle events, priority reset > flush > write > lookup update:
  - flush + req_valid: response issued with tlb_miss=1, tlb_fault=0, PhysicalAddress=0 (user) or bypass value (supervisor).
  - flush + tlb_write: write dropped.
  - write + req_valid: lookup sees pre-write contents; lookup hit responds normally, but only the write's LRU touch is applied.
- VPN compare is full VPN_W width; no partial tags.

Test Plan:
- Reset; user req VA=0x0000_5123 -> next cycle resp_valid=1, tlb_miss=1, PhysicalAddress=0x00000.
- Write VPN 0x00005 -> PPN 0xA7, user_ok=1. Then user req VA=0x0000_5123 -> PhysicalAddress=0xA7123, tlb_miss=0, tlb_fault=0.
- Fill VPNs 1,2,3,4 (entries 0..3); touch VPN 1 by lookup; write VPN 9 -> VPN 2 (entry 1, oldest) evicted. Lookup VPN 2 misses; VPNs 1, 3, 4 and 9 hit.
- Write VPN 0x00007 -> PPN 0x11, user_ok=0. User req 0x0000_7004 -> tlb_fault=1, tlb_miss=0. Supervisor req 0x1234_5678 -> PhysicalAddress=0x45678, no fault.
- Write VPN 5 -> PPN 0x01, then VPN 5 -> PPN 0x02 -> one entry used, lookup gives PPN 0x02. Next write of VPN 6 goes to the next invalid entry.
- Flush asserted with req_valid and tlb_write in the same cycle -> response tlb_miss=1; all later lookups miss; the write is not installed.

Source files
------------

// File: rtl/itlb_assoc.sv
// Fully associative instruction TLB with true-LRU replacement, duplicate-free refill,
// per-page user permission and a registered one-cycle lookup response.
module itlb_assoc #(
  parameter int unsigned ENTRIES   = 4,
  parameter int unsigned VA_WIDTH  = 32,
  parameter int unsigned PAGE_BITS = 12,
  parameter int unsigned PPN_WIDTH = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               flush,
  input  logic                               req_valid,
  input  logic [VA_WIDTH-1:0]                VirtualAddress,
  input  logic                               supervisor_mode,
  input  logic                               tlb_write,
  input  logic [VA_WIDTH-PAGE_BITS-1:0]      reg_logic_page,
  input  logic [PPN_WIDTH-1:0]               reg_physical_page,
  input  logic                               reg_user_ok,
  output logic                               resp_valid,
  output logic [PPN_WIDTH+PAGE_BITS-1:0]     PhysicalAddress,
  output logic                               tlb_miss,
  output logic                               tlb_fault
);
  localparam int unsigned VPN_W = VA_WIDTH - PAGE_BITS;
  localparam int unsigned PA_W  = PPN_WIDTH + PAGE_BITS;
  localparam int unsigned IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  logic                 valid_q   [ENTRIES];
  logic [VPN_W-1:0]     vpn_q     [ENTRIES];
  logic [PPN_WIDTH-1:0] ppn_q     [ENTRIES];
  logic                 user_ok_q [ENTRIES];
  logic [IDX_W-1:0]     age_q     [ENTRIES];
  logic [IDX_W-1:0]     age_d     [ENTRIES];

  logic [VPN_W-1:0] req_vpn;
  logic             hit_c;
  logic [IDX_W-1:0] hit_idx;
  logic             wr_match, free_found;
  logic [IDX_W-1:0] wr_match_idx, free_idx, lru_idx, tgt_idx;
  logic             touch_en;
  logic [IDX_W-1:0] touch_idx;
  logic [PA_W-1:0]  pa_d;
  logic             miss_d, fault_d;

  assign req_vpn = VirtualAddress[VA_WIDTH-1:PAGE_BITS];

  // Lookup and refill target selection; lowest index wins every search.
  always_comb begin
    hit_c        = 1'b0;
    hit_idx      = '0;
    wr_match     = 1'b0;
    wr_match_idx = '0;
    free_found   = 1'b0;
    free_idx     = '0;
    lru_idx      = '0;
    for (int i = 0; i < int'(ENTRIES); i++) begin
      if (!hit_c && valid_q[i] && vpn_q[i] == req_vpn) begin
        hit_c   = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (!wr_match && valid_q[i] && vpn_q[i] == reg_logic_page) begin
        wr_match     = 1'b1;
        wr_match_idx = IDX_W'(i);
      end
      if (!free_found && !valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (age_q[i] == IDX_W'(ENTRIES - 1)) lru_idx = IDX_W'(i);
    end
    tgt_idx = wr_match ? wr_match_idx : (free_found ? free_idx : lru_idx);
  end

  // LRU touch: a refill's touch takes precedence over a lookup's; flush touches nothing.
  always_comb begin
    touch_en  = 1'b0;
    touch_idx = '0;
    if (!flush) begin
      if (tlb_write) begin
        touch_en  = 1'b1;
        touch_idx = tgt_idx;
      end else if (req_valid && !supervisor_mode && hit_c && user_ok_q[hit_idx]) begin
        touch_en  = 1'b1;
        touch_idx = hit_idx;
      end
    end
    for (int i = 0; i < int'(ENTRIES); i++) begin
      age_d[i] = age_q[i];
      if (touch_en && age_q[i] < age_q[touch_idx]) age_d[i] = age_q[i] + IDX_W'(1);
    end
    if (touch_en) age_d[touch_idx] = '0;
  end

  // Response payload computed from pre-edge contents.
  always_comb begin
    pa_d    = '0;
    miss_d  = 1'b0;
    fault_d = 1'b0;
    if (supervisor_mode) begin
      pa_d   = VirtualAddress[PA_W-1:0];
      miss_d = flush;
    end else if (flush || !hit_c) begin
      miss_d = 1'b1;
    end else if (user_ok_q[hit_idx]) begin
      pa_d = {ppn_q[hit_idx], VirtualAddress[PAGE_BITS-1:0]};
    end else begin
      fault_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        valid_q[i]   <= 1'b0;
        vpn_q[i]     <= '0;
        ppn_q[i]     <= '0;
        user_ok_q[i] <= 1'b0;
        age_q[i]     <= IDX_W'(i);
      end
      resp_valid      <= 1'b0;
      PhysicalAddress <= '0;
      tlb_miss        <= 1'b0;
      tlb_fault       <= 1'b0;
    end else begin
      resp_valid <= req_valid;
      if (req_valid) begin
        PhysicalAddress <= pa_d;
        tlb_miss        <= miss_d;
        tlb_fault       <= fault_d;
      end
      if (flush) begin
        for (int i = 0; i < int'(ENTRIES); i++) valid_q[i] <= 1'b0;
      end else if (tlb_write) begin
        valid_q[tgt_idx]   <= 1'b1;
        vpn_q[tgt_idx]     <= reg_logic_page;
        ppn_q[tgt_idx]     <= reg_physical_page;
        user_ok_q[tgt_idx] <= reg_user_ok;
      end
      age_q <= age_d;
    end
  end
endmodule

// File: tb/tb_itlb_assoc.sv
// Bench for itlb_assoc: directed scenarios plus random traffic against a queue-based LRU model.
module tb_itlb_assoc;
  logic        clk = 1'b0;
  logic        reset, flush, req_valid, supervisor_mode, tlb_write, reg_user_ok;
  logic [31:0] VirtualAddress;
  logic [19:0] reg_logic_page;
  logic [7:0]  reg_physical_page;
  logic        resp_valid, tlb_miss, tlb_fault;
  logic [19:0] PhysicalAddress;

  itlb_assoc dut (
    .clk(clk), .reset(reset), .flush(flush), .req_valid(req_valid),
    .VirtualAddress(VirtualAddress), .supervisor_mode(supervisor_mode),
    .tlb_write(tlb_write), .reg_logic_page(reg_logic_page),
    .reg_physical_page(reg_physical_page), .reg_user_ok(reg_user_ok),
    .resp_valid(resp_valid), .PhysicalAddress(PhysicalAddress),
    .tlb_miss(tlb_miss), .tlb_fault(tlb_fault)
  );

  always #5 clk = ~clk;

  // Model: entry contents plus recency list (front = most recent, back = eviction victim).
  bit          m_valid [4];
  logic [19:0] m_vpn   [4];
  logic [7:0]  m_ppn   [4];
  bit          m_uok   [4];
  int          order[$];
  logic        exp_rv, exp_miss, exp_fault;
  logic [19:0] exp_pa;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
  endtask

  task automatic touch(input int h);
    for (int j = 0; j < order.size(); j++)
      if (order[j] == h) begin
        order.delete(j);
        break;
      end
    order.push_front(h);
  endtask

  task automatic compare_outputs();
    check("resp_valid", 32'(resp_valid), 32'(exp_rv));
    check("phys_addr", 32'(PhysicalAddress), 32'(exp_pa));
    check("tlb_miss", 32'(tlb_miss), 32'(exp_miss));
    check("tlb_fault", 32'(tlb_fault), 32'(exp_fault));
  endtask

  task automatic do_reset();
    reset = 1'b0; flush = 1'b0; req_valid = 1'b1; VirtualAddress = 32'h0000_5123;
    supervisor_mode = 1'b0; tlb_write = 1'b1; reg_logic_page = 20'h5;
    reg_physical_page = 8'h1; reg_user_ok = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 4; i++) m_valid[i] = 0;
    order = '{0, 1, 2, 3};
    exp_rv = 0; exp_pa = '0; exp_miss = 0; exp_fault = 0;
    #1 compare_outputs();
    reset = 1'b1;
  endtask

  task automatic step(input bit fl, input bit rq, input logic [31:0] va, input bit sup,
                      input bit wr, input logic [19:0] wvpn, input logic [7:0] wppn, input bit wuok);
    int h, t;
    flush = fl; req_valid = rq; VirtualAddress = va; supervisor_mode = sup;
    tlb_write = wr; reg_logic_page = wvpn; reg_physical_page = wppn; reg_user_ok = wuok;
    @(posedge clk);
    h = -1;
    if (rq) begin
      exp_rv = 1; exp_pa = '0; exp_miss = 0; exp_fault = 0;
      if (sup) begin
        exp_pa = va[19:0];
        exp_miss = fl;
      end else if (fl) begin
        exp_miss = 1;
      end else begin
        for (int i = 0; i < 4; i++)
          if (h < 0 && m_valid[i] && m_vpn[i] == va[31:12]) h = i;
        if (h < 0) exp_miss = 1;
        else if (m_uok[h]) exp_pa = {m_ppn[h], va[11:0]};
        else exp_fault = 1;
      end
    end else exp_rv = 0;
    if (fl) begin
      for (int i = 0; i < 4; i++) m_valid[i] = 0;
    end else if (wr) begin
      t = -1;
      for (int i = 0; i < 4; i++) if (t < 0 && m_valid[i] && m_vpn[i] == wvpn) t = i;
      for (int i = 0; i < 4; i++) if (t < 0 && !m_valid[i]) t = i;
      if (t < 0) t = order[order.size()-1];
      m_valid[t] = 1; m_vpn[t] = wvpn; m_ppn[t] = wppn; m_uok[t] = wuok;
      touch(t);
    end else if (rq && !sup && h >= 0 && m_uok[h]) touch(h);
    #1 compare_outputs();
  endtask

  task automatic lookup(input logic [31:0] va);
    step(0, 1, va, 0, 0, '0, '0, 0);
  endtask

  task automatic write(input logic [19:0] vpn, input logic [7:0] ppn, input bit uok);
    step(0, 0, '0, 0, 1, vpn, ppn, uok);
  endtask

  initial begin
    logic [19:0] rv;
    do_reset();
    lookup(32'h0000_5123);
    check("s1_valid", 32'(resp_valid), 32'd1);
    check("s1_miss", 32'(tlb_miss), 32'd1);
    check("s1_pa", 32'(PhysicalAddress), 32'h0);
    write(20'h5, 8'hA7, 1);
    lookup(32'h0000_5123);
    check("s2_pa", 32'(PhysicalAddress), 32'hA7123);
    check("s2_miss", 32'(tlb_miss), 32'd0);
    check("s2_fault", 32'(tlb_fault), 32'd0);

    do_reset();
    for (int k = 1; k <= 4; k++) write(20'(k), 8'(8'h10 + k), 1);
    lookup(32'h0000_1abc);
    write(20'h9, 8'h99, 1);
    lookup(32'h0000_2000);
    check("evict_miss2", 32'(tlb_miss), 32'd1);
    lookup(32'h0000_1004);
    check("hit1_pa", 32'(PhysicalAddress), 32'h11004);
    lookup(32'h0000_3fff);
    check("hit3_pa", 32'(PhysicalAddress), 32'h13fff);
    lookup(32'h0000_4010);
    check("hit4_pa", 32'(PhysicalAddress), 32'h14010);
    lookup(32'h0000_9321);
    check("hit9_pa", 32'(PhysicalAddress), 32'h99321);

    write(20'h7, 8'h11, 0);
    lookup(32'h0000_7004);
    check("perm_fault", 32'(tlb_fault), 32'd1);
    check("perm_miss", 32'(tlb_miss), 32'd0);
    check("perm_pa", 32'(PhysicalAddress), 32'h0);
    step(0, 1, 32'h1234_5678, 1, 0, '0, '0, 0);
    check("sup_pa", 32'(PhysicalAddress), 32'h45678);
    check("sup_fault", 32'(tlb_fault), 32'd0);

    do_reset();
    write(20'h5, 8'h01, 1);
    write(20'h5, 8'h02, 1);
    lookup(32'h0000_5abc);
    check("dup_pa", 32'(PhysicalAddress), 32'h02abc);
    write(20'h6, 8'h06, 1);
    write(20'h7, 8'h07, 1);
    write(20'h8, 8'h08, 1);
    lookup(32'h0000_5001);
    check("dup_keep5", 32'(tlb_miss), 32'd0);
    lookup(32'h0000_6001);
    check("dup_keep6", 32'(PhysicalAddress), 32'h06001);

    step(1, 1, 32'h0000_6001, 0, 1, 20'h20, 8'h33, 1);
    check("flush_miss", 32'(tlb_miss), 32'd1);
    check("flush_valid", 32'(resp_valid), 32'd1);
    lookup(32'h0000_7000);
    check("post_flush7", 32'(tlb_miss), 32'd1);
    lookup(32'h0002_0000);
    check("flush_wr_drop", 32'(tlb_miss), 32'd1);
    step(0, 0, '0, 0, 0, '0, '0, 0);
    check("idle_valid", 32'(resp_valid), 32'd0);
    check("idle_hold", 32'(tlb_miss), 32'd1);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      else begin
        rv = ($urandom_range(0, 9) == 0) ? 20'($urandom) : 20'($urandom_range(0, 7));
        step($urandom_range(0, 39) == 0, 1'($urandom), {rv, 12'($urandom)},
             $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
             20'($urandom_range(0, 7)), 8'($urandom), $urandom_range(0, 3) != 0);
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
